// File: rtl/match_referee_if.sv
// match_referee_if: player state codes in, health/timer/round/winner status out.
interface match_referee_if;
  logic       start;
  logic [3:0] p1_state;
  logic [3:0] p2_state;
  logic [6:0] p1_health;
  logic [6:0] p2_health;
  logic [6:0] timer_sec;
  logic [1:0] p1_rounds;
  logic [1:0] p2_rounds;
  logic [1:0] round_winner;
  logic [1:0] match_winner;
  logic       freeze;
  logic       round_reset;
  logic [1:0] ref_state;
  modport master (
    output start, p1_state, p2_state,
    input  p1_health, p2_health, timer_sec, p1_rounds, p2_rounds,
           round_winner, match_winner, freeze, round_reset, ref_state
  );
  modport slave (
    input  start, p1_state, p2_state,
    output p1_health, p2_health, timer_sec, p1_rounds, p2_rounds,
           round_winner, match_winner, freeze, round_reset, ref_state
  );
endinterface

// File: rtl/match_referee.sv
// match_referee: detects hits/blocks from controller state edges and runs health, timer, rounds and match.
module match_referee #(
  parameter logic [6:0] MAX_HEALTH     = 7'd100,
  parameter logic [6:0] I_DAMAGE       = 7'd10,
  parameter logic [6:0] D_DAMAGE       = 7'd15,
  parameter logic [6:0] CHIP_DAMAGE    = 7'd2,
  parameter logic [5:0] FRAMES_PER_SEC = 6'd60,
  parameter logic [6:0] ROUND_TIME     = 7'd99,
  parameter logic [7:0] READY_FRAMES   = 8'd120,
  parameter logic [7:0] END_FRAMES     = 8'd180,
  parameter logic [1:0] ROUNDS_TO_WIN  = 2'd2
) (
  input logic            logic_clk,
  input logic            reset,
  match_referee_if.slave bus
);
  typedef enum logic [1:0] {PRE_ROUND, FIGHT, ROUND_END, MATCH_OVER} state_t;
  state_t     state, state_n;
  logic [7:0] cnt;
  logic [6:0] h1, h2, timer, dmg1, dmg2;
  logic [3:0] prev1, prev2;
  logic [1:0] r1, r2, rw, mw, win;
  logic       fight, hit1, hit2, blk1, blk2, atk1, atk2, ko, sec_wrap, match_done;
  assign fight      = (state == FIGHT);
  assign hit1       = (bus.p1_state == 4'd9) && (prev1 != 4'd9);
  assign hit2       = (bus.p2_state == 4'd9) && (prev2 != 4'd9);
  assign blk1       = (bus.p1_state == 4'd10) && (prev1 != 4'd10);
  assign blk2       = (bus.p2_state == 4'd10) && (prev2 != 4'd10);
  assign atk1       = (bus.p1_state == 4'd7) || (bus.p1_state == 4'd8);
  assign atk2       = (bus.p2_state == 4'd7) || (bus.p2_state == 4'd8);
  assign dmg1       = !fight ? 7'd0 : hit1 ? (atk2 ? D_DAMAGE : I_DAMAGE) : blk1 ? CHIP_DAMAGE : 7'd0;
  assign dmg2       = !fight ? 7'd0 : hit2 ? (atk1 ? D_DAMAGE : I_DAMAGE) : blk2 ? CHIP_DAMAGE : 7'd0;
  assign ko         = (h1 == 7'd0) || (h2 == 7'd0);
  assign sec_wrap   = (cnt == {2'b00, FRAMES_PER_SEC - 6'd1});
  assign match_done = (r1 == ROUNDS_TO_WIN) || (r2 == ROUNDS_TO_WIN);
  // Knockouts dominate; otherwise (timeout) the healthier player takes the round.
  assign win = (h1 == 7'd0 && h2 == 7'd0) ? 2'b11 : (h1 == 7'd0) ? 2'b10 : (h2 == 7'd0) ? 2'b01 :
               (h1 > h2) ? 2'b01 : (h2 > h1) ? 2'b10 : 2'b11;
  always_ff @(posedge logic_clk or posedge reset)
    if (reset) state <= PRE_ROUND;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      PRE_ROUND:  state_n = (cnt == READY_FRAMES - 8'd1) ? FIGHT : PRE_ROUND;
      FIGHT:      state_n = (ko || timer == 7'd0) ? ROUND_END : FIGHT;
      ROUND_END:  state_n = (cnt != END_FRAMES - 8'd1) ? ROUND_END : match_done ? MATCH_OVER : PRE_ROUND;
      MATCH_OVER: state_n = bus.start ? PRE_ROUND : MATCH_OVER;
      default:    state_n = state;
    endcase
  end
  always_ff @(posedge logic_clk or posedge reset)
    if (reset) begin
      cnt   <= 8'd0;
      h1    <= MAX_HEALTH;
      h2    <= MAX_HEALTH;
      timer <= ROUND_TIME;
      r1    <= 2'd0;
      r2    <= 2'd0;
      rw    <= 2'd0;
      mw    <= 2'd0;
      prev1 <= 4'd0;
      prev2 <= 4'd0;
    end else begin
      prev1 <= bus.p1_state;
      prev2 <= bus.p2_state;
      case (state)
        PRE_ROUND: cnt <= (state_n == FIGHT) ? 8'd0 : cnt + 8'd1;
        FIGHT: begin
          cnt <= (state_n == ROUND_END || sec_wrap) ? 8'd0 : cnt + 8'd1;
          if (sec_wrap && timer != 7'd0) timer <= timer - 7'd1;
          h1 <= (h1 > dmg1) ? h1 - dmg1 : 7'd0;
          h2 <= (h2 > dmg2) ? h2 - dmg2 : 7'd0;
          if (state_n == ROUND_END) begin
            rw <= win;
            if (win == 2'b01 && r1 != 2'd3) r1 <= r1 + 2'd1;
            if (win == 2'b10 && r2 != 2'd3) r2 <= r2 + 2'd1;
          end
        end
        ROUND_END: begin
          cnt <= (state_n == ROUND_END) ? cnt + 8'd1 : 8'd0;
          if (state_n == MATCH_OVER) mw <= (r1 == ROUNDS_TO_WIN) ? 2'b01 : 2'b10;
          if (state_n == PRE_ROUND) begin
            h1    <= MAX_HEALTH;
            h2    <= MAX_HEALTH;
            timer <= ROUND_TIME;
          end
        end
        default:
          if (state_n == PRE_ROUND) begin
            cnt   <= 8'd0;
            h1    <= MAX_HEALTH;
            h2    <= MAX_HEALTH;
            timer <= ROUND_TIME;
            r1    <= 2'd0;
            r2    <= 2'd0;
            rw    <= 2'd0;
            mw    <= 2'd0;
          end
      endcase
    end
  assign bus.p1_health    = h1;
  assign bus.p2_health    = h2;
  assign bus.timer_sec    = timer;
  assign bus.p1_rounds    = r1;
  assign bus.p2_rounds    = r2;
  assign bus.round_winner = rw;
  assign bus.match_winner = mw;
  assign bus.freeze       = (state != FIGHT);
  assign bus.round_reset  = (state == PRE_ROUND);
  assign bus.ref_state    = state;
endmodule

// File: tb/tb_match_referee.sv
// tb_match_referee: directed scenarios plus random play against a frame-level match model, on a default and a fast-timer referee.
module tb_match_referee;
  logic       logic_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] p1 = 4'd0, p2 = 4'd0;
  int checks = 0, failures = 0;
  int fps[2] = '{60, 2};
  int rt[2]  = '{99, 3};
  int m_ph[2], m_cnt[2], m_h1[2], m_h2[2], m_t[2], m_r1[2], m_r2[2], m_rw[2], m_mw[2], m_pv1[2], m_pv2[2];
  match_referee_if ia();
  match_referee_if ib();
  assign ia.start = start;
  assign ia.p1_state = p1;
  assign ia.p2_state = p2;
  assign ib.start = start;
  assign ib.p1_state = p1;
  assign ib.p2_state = p2;
  match_referee u_a (.logic_clk(logic_clk), .reset(reset), .bus(ia));
  match_referee #(.FRAMES_PER_SEC(6'd2), .ROUND_TIME(7'd3)) u_b (.logic_clk(logic_clk), .reset(reset), .bus(ib));
  always #5 logic_clk = ~logic_clk;

  function automatic logic [32:0] va();
    return {ia.p1_health, ia.p2_health, ia.timer_sec, ia.p1_rounds, ia.p2_rounds,
            ia.round_winner, ia.match_winner, ia.freeze, ia.round_reset, ia.ref_state};
  endfunction
  function automatic logic [32:0] vb();
    return {ib.p1_health, ib.p2_health, ib.timer_sec, ib.p1_rounds, ib.p2_rounds,
            ib.round_winner, ib.match_winner, ib.freeze, ib.round_reset, ib.ref_state};
  endfunction
  function automatic logic [32:0] mv(input int k);
    return {7'(m_h1[k]), 7'(m_h2[k]), 7'(m_t[k]), 2'(m_r1[k]), 2'(m_r2[k]), 2'(m_rw[k]), 2'(m_mw[k]),
            1'(m_ph[k] != 1), 1'(m_ph[k] == 0), 2'(m_ph[k])};
  endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_cnt[k] = 0; m_h1[k] = 100; m_h2[k] = 100; m_t[k] = rt[k];
      m_r1[k] = 0; m_r2[k] = 0; m_rw[k] = 0; m_mw[k] = 0; m_pv1[k] = 0; m_pv2[k] = 0;
    end
  endtask

  task automatic mstep(input int k);
    int d1, d2, w, h1, h2;
    d1 = 0; d2 = 0; h1 = m_h1[k]; h2 = m_h2[k];
    if (m_ph[k] == 1) begin
      if (p1 == 9 && m_pv1[k] != 9) d1 = (p2 == 7 || p2 == 8) ? 15 : 10;
      else if (p1 == 10 && m_pv1[k] != 10) d1 = 2;
      if (p2 == 9 && m_pv2[k] != 9) d2 = (p1 == 7 || p1 == 8) ? 15 : 10;
      else if (p2 == 10 && m_pv2[k] != 10) d2 = 2;
    end
    case (m_ph[k])
      0: if (m_cnt[k] == 119) begin m_ph[k] = 1; m_cnt[k] = 0; end else m_cnt[k]++;
      1: begin
        if (m_cnt[k] == fps[k] - 1) begin m_cnt[k] = 0; if (m_t[k] > 0) m_t[k]--; end
        else m_cnt[k]++;
        if (h1 == 0 || h2 == 0 || m_t[k] == 0 && (m_cnt[k] != 0 || fps[k] == 1 || h1 == h1)) begin
        end
        m_h1[k] = (h1 > d1) ? h1 - d1 : 0;
        m_h2[k] = (h2 > d2) ? h2 - d2 : 0;
      end
      2: if (m_cnt[k] == 179) begin
        m_cnt[k] = 0;
        if (m_r1[k] == 2 || m_r2[k] == 2) begin m_mw[k] = (m_r1[k] == 2) ? 1 : 2; m_ph[k] = 3; end
        else begin m_h1[k] = 100; m_h2[k] = 100; m_t[k] = rt[k]; m_ph[k] = 0; end
      end else m_cnt[k]++;
      default: if (start) begin
        m_r1[k] = 0; m_r2[k] = 0; m_rw[k] = 0; m_mw[k] = 0;
        m_h1[k] = 100; m_h2[k] = 100; m_t[k] = rt[k]; m_cnt[k] = 0; m_ph[k] = 0;
      end
    endcase
    m_pv1[k] = p1; m_pv2[k] = p2;
  endtask

  int ph_before[2], t_before[2];
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge logic_clk);
      if (reset) mreset();
      else for (int k = 0; k < 2; k++) begin
        t_before[k] = m_t[k];
        ph_before[k] = m_ph[k];
        if (m_ph[k] == 1 && (m_h1[k] == 0 || m_h2[k] == 0 || m_t[k] == 0)) begin
          int w;
          w = (m_h1[k] == 0 && m_h2[k] == 0) ? 3 : (m_h1[k] == 0) ? 2 : (m_h2[k] == 0) ? 1 :
              (m_h1[k] > m_h2[k]) ? 1 : (m_h2[k] > m_h1[k]) ? 2 : 3;
          mstep(k);
          m_rw[k] = w;
          if (w == 1) m_r1[k] = (m_r1[k] < 3) ? m_r1[k] + 1 : 3;
          if (w == 2) m_r2[k] = (m_r2[k] < 3) ? m_r2[k] + 1 : 3;
          m_ph[k] = 2;
          m_cnt[k] = 0;
        end else mstep(k);
      end
      @(negedge logic_clk);
    end
  endtask

  task automatic do_reset();
    p1 = 0; p2 = 0; start = 0; reset = 1'b1; mreset();
    tick(2);
    reset = 1'b0;
  endtask

  task automatic hit(input bit on_p1, input logic [3:0] atk, input bit blk);
    p1 = 0; p2 = 0;
    tick(1);
    if (on_p1) begin p1 = blk ? 4'd10 : 4'd9; p2 = atk; end
    else begin p2 = blk ? 4'd10 : 4'd9; p1 = atk; end
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (va() !== {7'd100, 7'd100, 7'd99, 8'd0, 1'b1, 1'b1, 2'd0}) begin
      failures++; $display("FAIL reset_a got=%h exp=%h", va(), {7'd100, 7'd100, 7'd99, 8'd0, 1'b1, 1'b1, 2'd0});
    end
    checks++;
    if (vb() !== {7'd100, 7'd100, 7'd3, 8'd0, 1'b1, 1'b1, 2'd0}) begin
      failures++; $display("FAIL reset_b got=%h exp=%h", vb(), {7'd100, 7'd100, 7'd3, 8'd0, 1'b1, 1'b1, 2'd0});
    end
  endtask

  task automatic test_pre_round();
    tick(119);
    checks++;
    if (ia.ref_state !== 2'd0 || ia.round_reset !== 1'b1) begin
      failures++; $display("FAIL pre_hold got=%0d/%0b exp=0/1", ia.ref_state, ia.round_reset);
    end
    tick(1);
    checks++;
    if (va() !== {7'd100, 7'd100, 7'd99, 8'd0, 1'b0, 1'b0, 2'd1}) begin
      failures++; $display("FAIL pre_to_fight got=%h exp=%h", va(), {7'd100, 7'd100, 7'd99, 8'd0, 1'b0, 1'b0, 2'd1});
    end
  endtask

  task automatic test_hit();
    p1 = 4'd4; p2 = 4'd9;
    tick(1);
    checks++;
    if (ia.p2_health !== 7'd90) begin failures++; $display("FAIL hit_idle got=%0d exp=90", ia.p2_health); end
    tick(3);
    checks++;
    if (ia.p2_health !== 7'd90) begin failures++; $display("FAIL hit_held got=%0d exp=90", ia.p2_health); end
    p2 = 4'd0;
    tick(1);
    p1 = 4'd7; p2 = 4'd9;
    tick(1);
    checks++;
    if ({ia.p1_health, ia.p2_health} !== {7'd100, 7'd75}) begin
      failures++; $display("FAIL hit_dir got=%0d/%0d exp=100/75", ia.p1_health, ia.p2_health);
    end
  endtask

  task automatic test_block_ko();
    hit(1, 4'd8, 1);
    checks++;
    if (ia.p1_health !== 7'd98) begin failures++; $display("FAIL block_chip got=%0d exp=98", ia.p1_health); end
    repeat (5) hit(1, 4'd7, 0);
    repeat (2) hit(1, 4'd4, 0);
    hit(1, 4'd0, 1);
    checks++;
    if (ia.p1_health !== 7'd1) begin failures++; $display("FAIL health_one got=%0d exp=1", ia.p1_health); end
    hit(1, 4'd4, 0);
    checks++;
    if (ia.p1_health !== 7'd0 || ia.ref_state !== 2'd1) begin
      failures++; $display("FAIL ko_saturate got=%0d st=%0d exp=0 st=1", ia.p1_health, ia.ref_state);
    end
    p1 = 0; p2 = 0;
    tick(1);
    checks++;
    if ({ia.ref_state, ia.round_winner, ia.p1_rounds, ia.p2_rounds, ia.freeze} !== {2'd2, 2'd2, 2'd0, 2'd1, 1'b1}) begin
      failures++; $display("FAIL ko_round_end got=st%0d rw%0d r%0d/%0d exp=st2 rw2 r0/1",
                           ia.ref_state, ia.round_winner, ia.p1_rounds, ia.p2_rounds);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tick(120);
    p1 = 4'd9; p2 = 4'd9;
    tick(1);
    p1 = 0; p2 = 0;
    tick(1);
    p2 = 4'd9;
    tick(1);
    p2 = 0;
    tick(3);
    checks++;
    if ({ib.timer_sec, ib.ref_state} !== {7'd0, 2'd1}) begin
      failures++; $display("FAIL timer_zero got=%0d st=%0d exp=0 st=1", ib.timer_sec, ib.ref_state);
    end
    tick(1);
    checks++;
    if ({ib.ref_state, ib.round_winner, ib.p1_rounds, ib.p2_rounds, ib.p1_health, ib.p2_health} !==
        {2'd2, 2'd1, 2'd1, 2'd0, 7'd90, 7'd80}) begin
      failures++; $display("FAIL timeout_win got=st%0d rw%0d r%0d/%0d h%0d/%0d exp=st2 rw1 r1/0 h90/80",
                           ib.ref_state, ib.round_winner, ib.p1_rounds, ib.p2_rounds, ib.p1_health, ib.p2_health);
    end
    tick(179);
    checks++;
    if (ib.ref_state !== 2'd2) begin failures++; $display("FAIL end_hold got=%0d exp=2", ib.ref_state); end
    tick(1);
    checks++;
    if (vb() !== {7'd100, 7'd100, 7'd3, 2'd1, 2'd0, 2'd1, 2'd0, 1'b1, 1'b1, 2'd0}) begin
      failures++; $display("FAIL reload got=%h exp=%h", vb(), {7'd100, 7'd100, 7'd3, 2'd1, 2'd0, 2'd1, 2'd0, 1'b1, 1'b1, 2'd0});
    end
    tick(127);
    checks++;
    if ({ib.ref_state, ib.round_winner, ib.p1_rounds, ib.p2_rounds} !== {2'd2, 2'd3, 2'd1, 2'd0}) begin
      failures++; $display("FAIL timeout_draw got=st%0d rw%0d r%0d/%0d exp=st2 rw3 r1/0",
                           ib.ref_state, ib.round_winner, ib.p1_rounds, ib.p2_rounds);
    end
  endtask

  task automatic test_double_ko();
    do_reset();
    tick(120);
    repeat (6) begin hit(1, 4'd7, 0); hit(0, 4'd7, 0); end
    checks++;
    if ({ia.p1_health, ia.p2_health} !== {7'd10, 7'd10}) begin
      failures++; $display("FAIL pre_dko got=%0d/%0d exp=10/10", ia.p1_health, ia.p2_health);
    end
    p1 = 0; p2 = 0;
    tick(1);
    p1 = 4'd9; p2 = 4'd9;
    tick(1);
    checks++;
    if ({ia.p1_health, ia.p2_health} !== {7'd0, 7'd0}) begin
      failures++; $display("FAIL dko_health got=%0d/%0d exp=0/0", ia.p1_health, ia.p2_health);
    end
    p1 = 0; p2 = 0;
    tick(1);
    checks++;
    if ({ia.ref_state, ia.round_winner, ia.p1_rounds, ia.p2_rounds} !== {2'd2, 2'd3, 2'd0, 2'd0}) begin
      failures++; $display("FAIL dko_draw got=st%0d rw%0d r%0d/%0d exp=st2 rw3 r0/0",
                           ia.ref_state, ia.round_winner, ia.p1_rounds, ia.p2_rounds);
    end
  endtask

  task automatic test_match();
    do_reset();
    repeat (2) begin
      tick(120);
      p2 = 4'd9;
      tick(1);
      p2 = 0;
      tick(6);
      if (ib.p1_rounds != 2'd2) tick(180);
    end
    checks++;
    if ({ib.ref_state, ib.round_winner, ib.p1_rounds} !== {2'd2, 2'd1, 2'd2}) begin
      failures++; $display("FAIL second_round got=st%0d rw%0d r%0d exp=st2 rw1 r2", ib.ref_state, ib.round_winner, ib.p1_rounds);
    end
    tick(180);
    checks++;
    if ({ib.ref_state, ib.match_winner} !== {2'd3, 2'd1}) begin
      failures++; $display("FAIL match_over got=st%0d mw%0d exp=st3 mw1", ib.ref_state, ib.match_winner);
    end
    tick(20);
    checks++;
    if ({ib.ref_state, ib.match_winner, ib.p1_rounds} !== {2'd3, 2'd1, 2'd2}) begin
      failures++; $display("FAIL match_hold got=st%0d mw%0d r%0d exp=st3 mw1 r2", ib.ref_state, ib.match_winner, ib.p1_rounds);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checks++;
    if (vb() !== {7'd100, 7'd100, 7'd3, 8'd0, 1'b1, 1'b1, 2'd0}) begin
      failures++; $display("FAIL restart got=%h exp=%h", vb(), {7'd100, 7'd100, 7'd3, 8'd0, 1'b1, 1'b1, 2'd0});
    end
    tick(120);
    p1 = 4'd9;
    tick(1);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (va() !== {7'd100, 7'd100, 7'd99, 8'd0, 1'b1, 1'b1, 2'd0}) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", va(), {7'd100, 7'd100, 7'd99, 8'd0, 1'b1, 1'b1, 2'd0});
    end
    mreset();
    p1 = 0;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_random();
    int codes[7] = '{0, 4, 5, 7, 8, 9, 10};
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 2) == 0) p1 = 4'(codes[$urandom_range(0, 6)]);
      if ($urandom_range(0, 2) == 0) p2 = 4'(codes[$urandom_range(0, 6)]);
      start = ($urandom_range(0, 39) == 0);
      tick(1);
      checks++;
      if (va() !== mv(0)) begin failures++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", i, va(), mv(0)); end
      checks++;
      if (vb() !== mv(1)) begin failures++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", i, vb(), mv(1)); end
    end
    start = 0;
  endtask

  initial begin
    test_reset();
    test_pre_round();
    test_hit();
    test_block_ko();
    test_timeout();
    test_double_ko();
    test_match();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
